// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the handshaked EX-stage ALU (alu_seq) and its
// iterative multiply/divide core (alu_muldiv_iter).
//   alu_op_e     : 5-bit operation codes driven on Operation
//   alu_state_e  : FSM state encoding (also visible on alu_seq.o_dbg_state)
//   is_muldiv()  : 1 for the iterative MUL/MULHU/DIV/DIVU/REM/REMU codes
//   is_mul_op()  : 1 for MUL/MULHU (selects the multiplier path)
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [4:0] {
        OP_AND   = 5'b00000,
        OP_XOR   = 5'b00001,
        OP_OR    = 5'b00010,
        OP_ADD   = 5'b00011,
        OP_SUB   = 5'b00100,
        OP_EQ    = 5'b00101,
        OP_NE    = 5'b00110,
        OP_SLT   = 5'b00111,
        OP_SGE   = 5'b01000,
        OP_SRL   = 5'b01001,
        OP_SLL   = 5'b01010,
        OP_SRA   = 5'b01011,
        OP_SLTU  = 5'b01100,
        OP_SGEU  = 5'b01101,
        OP_TRUE  = 5'b01111,
        OP_MUL   = 5'b10000,
        OP_MULHU = 5'b10001,
        OP_DIV   = 5'b10010,
        OP_DIVU  = 5'b10011,
        OP_REM   = 5'b10100,
        OP_REMU  = 5'b10101
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// alu_muldiv_iter
// Iterative multiply / divide core, one result bit per clock, DATA_WIDTH steps.
//   Multiply : shift-add on {hi,lo}; MUL returns lo, MULHU returns hi.
//   Divide   : restoring divide on operand magnitudes; the sign fix and the
//              divide-by-zero quotient are folded into the final step.
// Ports
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   start      : 1-cycle pulse; latches op/a/b and begins a new operation
//   op         : MUL/MULHU/DIV/DIVU/REM/REMU code (alu_op_e)
//   a, b       : operands (a = dividend / multiplicand, b = divisor / multiplier)
//   done       : high during the cycle in which the last step is taken
//   result     : final value, valid while done is high
// -----------------------------------------------------------------------------
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    // Iteration state
    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_hi;      // product high half / partial remainder
    logic [W-1:0]  r_lo;      // multiplier bits / dividend bits -> quotient
    logic [W-1:0]  r_opnd;    // multiplicand or divisor magnitude
    logic          r_is_mul;
    logic          r_sel_hi;  // MULHU, REM, REMU take the high register
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_div0;

    // Operand preparation at start
    logic         w_signed;
    logic         w_a_neg;
    logic         w_b_neg;
    logic [W-1:0] w_a_mag;
    logic [W-1:0] w_b_mag;

    assign w_signed = (op == OP_DIV) || (op == OP_REM);
    assign w_a_neg  = w_signed & a[W-1];
    assign w_b_neg  = w_signed & b[W-1];
    assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;

    // One iteration step
    logic [W:0]   w_sum;      // hi + multiplicand, with carry
    logic [W:0]   w_shift;    // partial remainder shifted left by one
    logic         w_ge;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_hi_nxt;
    logic [W-1:0] w_lo_nxt;
    logic [W-1:0] w_quot;
    logic [W-1:0] w_rem;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    assign w_shift = {r_hi, r_lo[W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opnd});
    // When w_ge holds the true difference is below the divisor, so the low
    // W bits of the subtraction are exact.
    assign w_diff  = w_shift[W-1:0] - r_opnd;

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_is_mul) begin
            w_hi_nxt = w_sum[W:1];
            w_lo_nxt = {w_sum[0], r_lo[W-1:1]};
        end else begin
            w_hi_nxt = w_ge ? w_diff : w_shift[W-1:0];
            w_lo_nxt = {r_lo[W-2:0], w_ge};
        end
    end

    // Final fix-up, evaluated on the values the last step produces.
    // A zero divisor gives an all-ones quotient regardless of signs; the
    // remainder is then |a| re-signed, i.e. the dividend itself.
    // MIN / -1 needs no special case: |MIN| / 1 = MIN and the signs agree.
    always_comb begin
        w_quot = r_neg_q ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
        if (r_div0) begin
            w_quot = {W{1'b1}};
        end
        w_rem = r_neg_r ? (~w_hi_nxt + 1'b1) : w_hi_nxt;
    end

    always_comb begin
        result = '0;
        if (r_is_mul) begin
            result = r_sel_hi ? w_hi_nxt : w_lo_nxt;
        end else begin
            result = r_sel_hi ? w_rem : w_quot;
        end
    end

    assign done = r_busy && (r_cnt == CW'(W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_is_mul <= 1'b0;
            r_sel_hi <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_is_mul <= is_mul_op(op);
            r_sel_hi <= (op == OP_MULHU) || (op == OP_REM) || (op == OP_REMU);
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (b == '0);
            if (is_mul_op(op)) begin
                r_lo   <= b;
                r_opnd <= a;
            end else begin
                r_lo   <= w_a_mag;
                r_opnd <= w_b_mag;
            end
        end else if (r_busy) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == CW'(W - 1)) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Handshaked EX-stage ALU. Single-cycle ops (logic, add/sub, compares, shifts)
// produce a registered result one cycle after accept. MUL/MULHU/DIV/DIVU/
// REM/REMU run in alu_muldiv_iter for DATA_WIDTH cycles; the result appears
// DATA_WIDTH+1 cycles after accept.
//
// Handshake: an op is accepted on a rising edge where in_valid & in_ready.
// in_ready is high only in IDLE, so there is never back-to-back issue. A
// result is offered with out_valid=1 and held stable (ALUResult unchanged)
// until a rising edge where out_ready=1, after which the block returns to IDLE.
// Operands and Operation are captured at accept; later changes are ignored.
//
// Configuration macro: ALU_MULDIV_EN
//   defined   : MUL/DIV FSM states and the iterative core are built
//   undefined : codes 10000-10101 complete in one cycle with result 0
//
// Ports
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high; returns to IDLE, result cleared
//   in_valid    : SrcA/SrcB/Operation valid
//   in_ready    : block can accept (IDLE)
//   SrcA, SrcB  : operands
//   Operation   : op select (alu_op_e)
//   out_valid   : ALUResult valid (DONE)
//   out_ready   : consumer takes the result
//   ALUResult   : registered result
//   o_dbg_state : current FSM state (alu_state_e encoding)
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic [1:0]               o_dbg_state
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(W);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_DONE = ST_DONE;
`ifdef ALU_MULDIV_EN
    localparam logic [1:0] S_MUL  = ST_MUL;
    localparam logic [1:0] S_DIV  = ST_DIV;
`endif

    logic [1:0]    r_state;
    logic [W-1:0]  r_result;

    logic [4:0]    w_op;
    logic          w_accept;
    logic [SW-1:0] w_shamt;
    logic [W-1:0]  w_sc_result;

    assign w_op     = Operation[4:0];
    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_shamt  = SrcB[SW-1:0];

    // Single-cycle datapath. Codes outside the table, and the mul/div codes
    // when the iterative core is not built, yield 0.
    always_comb begin
        w_sc_result = '0;
        case (w_op)
            OP_AND:  w_sc_result = SrcA & SrcB;
            OP_XOR:  w_sc_result = SrcA ^ SrcB;
            OP_OR:   w_sc_result = SrcA | SrcB;
            OP_ADD:  w_sc_result = SrcA + SrcB;
            OP_SUB:  w_sc_result = SrcA - SrcB;
            OP_EQ:   w_sc_result = W'(SrcA == SrcB);
            OP_NE:   w_sc_result = W'(SrcA != SrcB);
            OP_SLT:  w_sc_result = W'($signed(SrcA) <  $signed(SrcB));
            OP_SGE:  w_sc_result = W'($signed(SrcA) >= $signed(SrcB));
            OP_SRL:  w_sc_result = SrcA >> w_shamt;
            OP_SLL:  w_sc_result = SrcA << w_shamt;
            OP_SRA:  w_sc_result = $unsigned($signed(SrcA) >>> w_shamt);
            OP_SLTU: w_sc_result = W'(SrcA <  SrcB);
            OP_SGEU: w_sc_result = W'(SrcA >= SrcB);
            OP_TRUE: w_sc_result = W'(1);
            default: w_sc_result = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic         w_start;
    logic         w_core_done;
    logic [W-1:0] w_core_result;

    assign w_start = w_accept && is_muldiv(w_op);

    alu_muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (w_start),
        .op     (w_op),
        .a      (SrcA),
        .b      (SrcB),
        .done   (w_core_done),
        .result (w_core_result)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
`ifdef ALU_MULDIV_EN
                        if (is_muldiv(w_op)) begin
                            r_state <= is_mul_op(w_op) ? S_MUL : S_DIV;
                        end else begin
                            r_result <= w_sc_result;
                            r_state  <= S_DONE;
                        end
`else
                        r_result <= w_sc_result;
                        r_state  <= S_DONE;
`endif
                    end
                end
`ifdef ALU_MULDIV_EN
                S_MUL, S_DIV: begin
                    // The core finishes its last step this cycle; capture it.
                    if (w_core_done) begin
                        r_result <= w_core_result;
                        r_state  <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign ALUResult   = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  // clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [4:0]   Operation;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic [1:0]   dbg_state;

  alu_seq #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .Operation  (Operation),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .o_dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // reference model, straight from the op table
  function automatic logic [W-1:0] ref_alu(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int sh;
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sh = int'(b % W);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p = {32'd0, a} * {32'd0, b};
    case (op)
      5'd0:  return a & b;
      5'd1:  return a ^ b;
      5'd2:  return a | b;
      5'd3:  return a + b;
      5'd4:  return a - b;
      5'd5:  return (a == b) ? 32'd1 : 32'd0;
      5'd6:  return (a != b) ? 32'd1 : 32'd0;
      5'd7:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd8:  return (sa >= sb) ? 32'd1 : 32'd0;
      5'd9:  return a >> sh;
      5'd10: return a << sh;
      5'd11: return 32'(sa >>> sh);
      5'd12: return (ua < ub) ? 32'd1 : 32'd0;
      5'd13: return (ua >= ub) ? 32'd1 : 32'd0;
      5'd15: return 32'd1;
      default: ;
    endcase
    if (!MD) return '0;
    case (op)
      5'd16: return p[31:0];
      5'd17: return p[63:32];
      5'd18: begin
        if (b == 0) return '1;
        q = sa / sb;
        return 32'(q);
      end
      5'd19: begin
        if (b == 0) return '1;
        q = ua / ub;
        return 32'(q);
      end
      5'd20: begin
        if (b == 0) return a;
        q = sa % sb;
        return 32'(q);
      end
      5'd21: begin
        if (b == 0) return a;
        q = ua % ub;
        return 32'(q);
      end
      default: return '0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] op);
    return (MD && op >= 5'd16 && op <= 5'd21) ? W + 1 : 1;
  endfunction

  function automatic logic [W-1:0] md(input logic [W-1:0] v);
    return MD ? v : '0;
  endfunction

  // driver: issue one op, wait for result, optionally stall the consumer
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit keep_valid,
                        output logic [W-1:0] res, output int lat);
    int guard;
    bit busy_ok;
    bit stable_ok;
    logic [W-1:0] held;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("idle_before_issue", 32'(in_ready), 32'd1);
    Operation = op;
    SrcA = a;
    SrcB = b;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    if (!keep_valid) in_valid = 1'b0;
    SrcA = $urandom;
    SrcB = $urandom;
    Operation = 5'($urandom_range(0, 31));
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (in_ready) busy_ok = 1'b0;
    check("busy_in_ready_low", 32'(busy_ok), 32'd1);
    res = ALUResult;
    if (hold > 0) begin
      held = ALUResult;
      stable_ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!out_valid || in_ready || ALUResult !== held) stable_ok = 1'b0;
      end
      check("stall_stable", 32'(stable_ok), 32'd1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("release_to_idle", 32'({in_ready, out_valid}), 32'd2);
  endtask

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [4:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] exp);
    vec_t v;
    v.op = op;
    v.a = a;
    v.b = b;
    v.exp = exp;
    return v;
  endfunction

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] exp;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0] op;
    int lat;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    SrcA = '0;
    SrcB = '0;
    Operation = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", ALUResult, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    vecs[0]  = mk(5'b00011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    vecs[1]  = mk(5'b01011, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    vecs[2]  = mk(5'b00111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    vecs[3]  = mk(5'b01100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    vecs[4]  = mk(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, md(32'h0000_0001));
    vecs[5]  = mk(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, md(32'hFFFF_FFFE));
    vecs[6]  = mk(5'b10010, 32'hFFFF_FFF9, 32'h0000_0002, md(32'hFFFF_FFFD));
    vecs[7]  = mk(5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, md(32'hFFFF_FFFF));
    vecs[8]  = mk(5'b10011, 32'h0000_0007, 32'h0000_0000, md(32'hFFFF_FFFF));
    vecs[9]  = mk(5'b10100, 32'h0000_0007, 32'h0000_0000, md(32'h0000_0007));
    vecs[10] = mk(5'b10010, 32'h8000_0000, 32'hFFFF_FFFF, md(32'h8000_0000));
    vecs[11] = mk(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, md(32'h0000_0000));
    vecs[12] = mk(5'b10010, 32'hFFFF_FFF8, 32'h0000_0000, md(32'hFFFF_FFFF));
    vecs[13] = mk(5'b10100, 32'hFFFF_FFF8, 32'h0000_0000, md(32'hFFFF_FFF8));
    vecs[14] = mk(5'b10010, 32'h0000_0005, 32'hFFFF_FFFD, md(32'hFFFF_FFFF));
    vecs[15] = mk(5'b10100, 32'h0000_0005, 32'hFFFF_FFFD, md(32'h0000_0002));
    vecs[16] = mk(5'b10011, 32'h0000_0064, 32'h0000_0007, md(32'h0000_000E));
    vecs[17] = mk(5'b10101, 32'h0000_0064, 32'h0000_0007, md(32'h0000_0002));
    vecs[18] = mk(5'b00100, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    vecs[19] = mk(5'b01000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
    vecs[20] = mk(5'b01101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
    vecs[21] = mk(5'b00101, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001);
    vecs[22] = mk(5'b00110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000);
    vecs[23] = mk(5'b01010, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
    vecs[24] = mk(5'b01001, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000);
    vecs[25] = mk(5'b01111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0001);
    vecs[26] = mk(5'b01110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    vecs[27] = mk(5'b00001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i % 6 == 3) ? 5 : 0, (i % 2 == 1), res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].op)));
    end

    // randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      exp_q.push_back(ref_alu(op, a, b));
      run_op(op, a, b, (n % 7 == 0) ? $urandom_range(1, 4) : 0, n[0], res, lat);
      exp = exp_q.pop_front();
      check($sformatf("rand%0d_op%0d", n, op), res, exp);
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(exp_lat(op)));
    end

    // reset in the middle of a divide
    Operation = 5'b10010;
    SrcA = 32'hFFFF_FFF9;
    SrcB = 32'h0000_0002;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midop_reset_in_ready", 32'(in_ready), 32'd1);
    check("midop_reset_out_valid", 32'(out_valid), 32'd0);
    check("midop_reset_result", ALUResult, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'(in_ready), 32'd1);
    run_op(5'b10010, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0, res, lat);
    check("post_reset_div", res, md(32'hFFFF_FFFD));
    check("post_reset_div_latency", 32'(lat), 32'(exp_lat(5'b10010)));
    run_op(5'b00011, 32'h0000_0010, 32'h0000_0020, 0, 1'b0, res, lat);
    check("post_reset_add", res, 32'h0000_0030);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
